// File: rtl/seg_param_calc.sv
// LTE code block segmentation parameter calculator: pops a transport block size B and
// iteratively derives C, K+, K-, C+, C- and F. Optional macro SEG_PARAM_ERR_EN adds param_err.
module seg_param_calc #(
   parameter int SIZE_W = 24,
   parameter int C_W    = 8,
   parameter int F_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty_size_fifo,
   output logic              read_size_fifo,
   input  logic [SIZE_W-1:0] size,
   output logic              param_valid,
   input  logic              param_ack,
   output logic [C_W-1:0]    c_num,
   output logic [C_W-1:0]    c_plus,
   output logic [C_W-1:0]    c_minus,
   output logic [12:0]       k_plus,
   output logic [12:0]       k_minus,
   output logic [F_W-1:0]    fill,
   output logic              busy
`ifdef SEG_PARAM_ERR_EN
   ,
   output logic              param_err
`endif
);

   localparam int P_W = ((C_W + 14) > (SIZE_W + 1)) ? (C_W + 14) : (SIZE_W + 1);
   localparam logic [SIZE_W-1:0] SEG_MAX  = SIZE_W'(6144);
   localparam logic [SIZE_W-1:0] SEG_DATA = SIZE_W'(6120);
   localparam logic [12:0]       K_MIN    = 13'd40;
   localparam logic [12:0]       K_MAX    = 13'd6144;
   localparam logic [C_W-1:0]    C_MAX    = '1;
   localparam logic [C_W-1:0]    C_ONE    = C_W'(1);
   localparam logic [P_W-1:0]    TWENTY4  = P_W'(24);

   typedef enum logic [2:0] {IDLE, FETCH, CCNT, KSRCH, CMIN, FILL, HOLD} state_t;

   state_t            state;
   logic [SIZE_W-1:0] b, b_prime, rem;
   logic [C_W-1:0]    c, c_p, c_m, c_inc, cm_calc;
   logic [12:0]       k, k_prev, k_p, k_m, k_step;
   logic [P_W-1:0]    prod_ck, prod_cp, bp_ext, slack;
   logic [SIZE_W-1:0] b_with_c;
   logic [F_W-1:0]    fill_calc;
`ifdef SEG_PARAM_ERR_EN
   logic              err;
`endif

   // NOTE: the strobe is decoded from state so the FIFO pops during IDLE and size is ready in FETCH.
   assign read_size_fifo = (state == IDLE) && !empty_size_fifo && !reset;
   assign busy           = (state != IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      k_step = 13'd64;
      if (k < 13'd512)       k_step = 13'd8;
      else if (k < 13'd1024) k_step = 13'd16;
      else if (k < 13'd2048) k_step = 13'd32;
      c_inc   = (c == C_MAX) ? c : c + C_ONE;
      prod_ck = P_W'(c) * P_W'(k);
      prod_cp = P_W'(c) * P_W'(k_p);
      bp_ext  = P_W'(b_prime);
      slack   = (prod_cp > bp_ext) ? prod_cp - bp_ext : '0;
      // K+ - K- is one table step, so the division is a fixed shift.
      case (k_p - k_m)
         13'd16:  cm_calc = C_W'(slack >> 4);
         13'd32:  cm_calc = C_W'(slack >> 5);
         13'd64:  cm_calc = C_W'(slack >> 6);
         default: cm_calc = C_W'(slack >> 3);
      endcase
      b_with_c  = SIZE_W'(P_W'(b) + P_W'(c_inc) * TWENTY4);
      fill_calc = F_W'(P_W'(c_p) * P_W'(k_p) + P_W'(c_m) * P_W'(k_m) - bp_ext);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset clears datapath working registers too, so an abandoned size leaves no residue.
      if (reset) begin
         state       <= IDLE;
         param_valid <= 1'b0;
         b           <= '0;
         b_prime     <= '0;
         rem         <= '0;
         c           <= '0;
         c_p         <= '0;
         c_m         <= '0;
         k           <= '0;
         k_prev      <= '0;
         k_p         <= '0;
         k_m         <= '0;
         c_num       <= '0;
         c_plus      <= '0;
         c_minus     <= '0;
         k_plus      <= '0;
         k_minus     <= '0;
         fill        <= '0;
`ifdef SEG_PARAM_ERR_EN
         err         <= 1'b0;
         param_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (!empty_size_fifo) state <= FETCH;
            FETCH: begin
               b      <= size;
               k      <= K_MIN;
               k_prev <= '0;
`ifdef SEG_PARAM_ERR_EN
               err    <= 1'b0;
               if (size == '0) begin
                  err   <= 1'b1;
                  state <= FILL;
               end else
`endif
               if (size <= SEG_MAX) begin
                  c       <= C_ONE;
                  b_prime <= size;
                  state   <= KSRCH;
               end else begin
                  c     <= '0;
                  rem   <= size;
                  state <= CCNT;
               end
            end
            CCNT: begin
`ifdef SEG_PARAM_ERR_EN
               if (c == C_MAX) begin
                  err   <= 1'b1;
                  state <= FILL;
               end else
`endif
               begin
                  c <= c_inc;
                  if (rem <= SEG_DATA) begin
                     b_prime <= b_with_c;
                     state   <= KSRCH;
                  end else begin
                     rem <= rem - SEG_DATA;
                  end
               end
            end
            KSRCH: begin
               // The K_MAX term only matters when C has saturated.
               if (prod_ck >= bp_ext || k == K_MAX) begin
                  k_p   <= k;
                  k_m   <= k_prev;
                  state <= CMIN;
               end else begin
                  k_prev <= k;
                  k      <= k + k_step;
               end
            end
            CMIN: begin
               if (c == C_ONE) begin
                  c_p <= C_ONE;
                  c_m <= '0;
                  k_m <= '0;
               end else begin
                  c_m <= cm_calc;
                  c_p <= c - cm_calc;
               end
               state <= FILL;
            end
            FILL: begin
               param_valid <= 1'b1;
               state       <= HOLD;
`ifdef SEG_PARAM_ERR_EN
               param_err   <= err;
               if (err) begin
                  c_num   <= '0;
                  c_plus  <= '0;
                  c_minus <= '0;
                  k_plus  <= '0;
                  k_minus <= '0;
                  fill    <= '0;
               end else
`endif
               begin
                  c_num   <= c;
                  c_plus  <= c_p;
                  c_minus <= c_m;
                  k_plus  <= k_p;
                  k_minus <= k_m;
                  fill    <= fill_calc;
               end
            end
            HOLD: begin
               if (param_ack) begin
                  param_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_param_calc.sv
// Directed bench for seg_param_calc: hand-computed LTE segmentation vectors, handshake
// ordering and mid-operation reset, with a small FIFO model feeding the size port.
module tb_seg_param_calc;

   localparam int SIZE_W = 24;
   localparam int C_W    = 8;
   localparam int F_W    = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              empty_size_fifo;
   logic              read_size_fifo;
   logic [SIZE_W-1:0] size = '0;
   logic              param_valid;
   logic              param_ack = 1'b0;
   logic [C_W-1:0]    c_num, c_plus, c_minus;
   logic [12:0]       k_plus, k_minus;
   logic [F_W-1:0]    fill;
   logic              busy;
`ifdef SEG_PARAM_ERR_EN
   logic              param_err;
`endif

   int checks = 0;
   int passed = 0;

   logic [SIZE_W-1:0] fifo_mem [8];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int reads  = 0;

   seg_param_calc #(.SIZE_W(SIZE_W), .C_W(C_W), .F_W(F_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .empty_size_fifo (empty_size_fifo),
      .read_size_fifo  (read_size_fifo),
      .size            (size),
      .param_valid     (param_valid),
      .param_ack       (param_ack),
      .c_num           (c_num),
      .c_plus          (c_plus),
      .c_minus         (c_minus),
      .k_plus          (k_plus),
      .k_minus         (k_minus),
      .fill            (fill),
      .busy            (busy)
`ifdef SEG_PARAM_ERR_EN
      ,
      .param_err       (param_err)
`endif
   );

   always #5 clk = ~clk;

   // Size FIFO model: data appears on the cycle after the pop strobe.
   assign empty_size_fifo = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (read_size_fifo) begin
         size   <= fifo_mem[rd_ptr % 8];
         rd_ptr <= rd_ptr + 1;
         reads  <= reads + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   task automatic push(input int b);
      fifo_mem[wr_ptr % 8] = SIZE_W'(b);
      wr_ptr++;
   endtask

   // Waits (bounded) for the pop strobe; called #1 after a falling edge.
   task automatic wait_strobe(input string name);
      for (int i = 0; i < 50; i++) begin
         if (read_size_fifo) break;
         @(negedge clk);
         #1;
      end
      check({name, "_strobe"}, 32'(read_size_fifo), 32'd1);
      check({name, "_busy_at_strobe"}, 32'(busy), 32'd0);
   endtask

   // Counts cycles strictly between the strobe cycle and the first param_valid cycle.
   task automatic wait_valid(input string name, input int exp_lat);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         if (param_valid) break;
         lat++;
      end while (lat < 400);
      check({name, "_valid"}, 32'(param_valid), 32'd1);
      if (exp_lat >= 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_params(input string name, input int e_c, input int e_kp, input int e_km,
                               input int e_cp, input int e_cm, input int e_f);
      check({name, "_c"},  32'(c_num),   32'(e_c));
      check({name, "_kp"}, 32'(k_plus),  32'(e_kp));
      check({name, "_km"}, 32'(k_minus), 32'(e_km));
      check({name, "_cp"}, 32'(c_plus),  32'(e_cp));
      check({name, "_cm"}, 32'(c_minus), 32'(e_cm));
      check({name, "_f"},  32'(fill),    32'(e_f));
   endtask

   task automatic run_vec(input string name, input int b, input int exp_lat, input int e_c,
                          input int e_kp, input int e_km, input int e_cp, input int e_cm, input int e_f);
      push(b);
      #1;
      wait_strobe(name);
      wait_valid(name, exp_lat);
      check_params(name, e_c, e_kp, e_km, e_cp, e_cm, e_f);
   endtask

   // Holds the ack off for 'delay' cycles, then acknowledges and checks the drop.
   task automatic ack_hold(input string name, input int delay, input int e_kp, input int e_f);
      repeat (delay) @(negedge clk);
      check({name, "_hold_valid"}, 32'(param_valid), 32'd1);
      check({name, "_hold_kp"},    32'(k_plus),      32'(e_kp));
      check({name, "_hold_f"},     32'(fill),        32'(e_f));
      param_ack = 1'b1;
      #1;
      check({name, "_no_read_in_ack"}, 32'(read_size_fifo), 32'd0);
      @(negedge clk);
      param_ack = 1'b0;
      check({name, "_valid_drop"}, 32'(param_valid), 32'd0);
      check({name, "_idle"},       32'(busy),        32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_read",  32'(read_size_fifo), 32'd0);
      check("rst_valid", 32'(param_valid),    32'd0);
      check("rst_busy",  32'(busy),           32'd0);
      check_params("rst", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_empty_no_read", 32'(read_size_fifo), 32'd0);

      run_vec("b40", 40, 4, 1, 40, 0, 1, 0, 0);
      ack_hold("b40", 1, 40, 0);
      run_vec("b100", 100, 12, 1, 104, 0, 1, 0, 4);
      ack_hold("b100", 0, 104, 4);
      run_vec("b6144", 6144, 191, 1, 6144, 0, 1, 0, 0);
      ack_hold("b6144", 0, 6144, 0);
      run_vec("b12240", 12240, 193, 2, 6144, 6080, 2, 0, 0);
      ack_hold("b12240", 0, 6144, 0);
      run_vec("b12288", 12288, 163, 3, 4160, 4096, 2, 1, 56);
      ack_hold("b12288", 0, 4160, 56);

`ifdef SEG_PARAM_ERR_EN
      run_vec("b0_err", 0, -1, 0, 0, 0, 0, 0, 0);
      check("b0_err_flag", 32'(param_err), 32'd1);
      ack_hold("b0_err", 0, 0, 0);
`else
      run_vec("b0", 0, 4, 1, 40, 0, 1, 0, 40);
      ack_hold("b0", 0, 40, 40);
`endif

      // Two queued sizes: first held for 5 cycles, second aborted by reset in KSRCH.
      reads = 0;
      push(6145);
      push(100);
      #1;
      wait_strobe("q1");
      wait_valid("q1", 146);
      check_params("q1", 2, 3136, 3072, 1, 1, 15);
      check("q1_one_read", 32'(reads), 32'd1);
      ack_hold("q1", 5, 3136, 15);
      check("q2_strobe_after_idle", 32'(read_size_fifo), 32'd1);
      repeat (3) @(negedge clk);
      check("q2_busy_ksrch", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("q2_rst_valid", 32'(param_valid), 32'd0);
      check("q2_rst_busy",  32'(busy),        32'd0);
      check("q2_rst_read",  32'(read_size_fifo), 32'd0);
      check_params("q2_rst", 0, 0, 0, 0, 0, 0);
      repeat (5) @(negedge clk);
      check("q2_no_extra_read", 32'(reads), 32'd2);
      check("q2_still_idle",    32'(busy),  32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
